// File: rtl/arith_pkg.sv
// Shared types and limits for the bit-serial arithmetic blocks.
package arith_pkg;

  // Largest operand width the serial datapath is sized for.
  localparam int WIDTH_MAX = 32;

  // Controller states for the serial subtractor.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/fullsub.sv
// One-bit full subtractor cell: d = a - b - bin, with borrow out.
// Gate-level so it mirrors the half/full adder cells.
module fullsub (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic axb;
  logic na;
  logic nxb;
  logic t_ab;
  logic t_bin;

  // Difference bit.
  xor u_x0 (axb, a, b);
  xor u_x1 (d, axb, bin);

  // Borrow: b exceeds a, or a equals b and a borrow is already pending.
  not u_n0 (na, a);
  not u_n1 (nxb, axb);
  and u_a0 (t_ab, na, b);
  and u_a1 (t_bin, nxb, bin);
  or  u_o0 (bout, t_ab, t_bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: D = A - B, LSB first, one bit per clock
// through a single fullsub cell, with valid/ready on both sides.
module serial_subtractor
  import arith_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] D,
  output logic             BO
);

  // One extra bit so WIDTH=1 still gets a legal counter.
  localparam int            CW   = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] d_sr_q, d_sr_d;
  logic             bor_q, bor_d;
  logic             bo_q, bo_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             fs_d;
  logic             fs_bout;

  // The single arithmetic cell, fed from the operand LSBs and running borrow.
  fullsub u_fs (
    .a    (a_sr_q[0]),
    .b    (b_sr_q[0]),
    .bin  (bor_q),
    .d    (fs_d),
    .bout (fs_bout)
  );

  // Next-state and datapath: load on accept, shift one bit per RUN cycle.
  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    d_sr_d  = d_sr_q;
    bor_d   = bor_q;
    bo_d    = bo_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        // A/B are only looked at here, so X on idle operands never leaks in.
        if (in_valid) begin
          a_sr_d  = A;
          b_sr_d  = B;
          bor_d   = 1'b0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // Difference bits enter at the MSB so after WIDTH shifts bit 0 is LSB.
        d_sr_d            = d_sr_q >> 1;
        d_sr_d[WIDTH-1]   = fs_d;
        a_sr_d            = a_sr_q >> 1;
        b_sr_d            = b_sr_q >> 1;
        bor_d             = fs_bout;
        cnt_d             = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          bo_d    = fs_bout;
          state_d = DONE;
        end
      end
      DONE: begin
        // Result held until the consumer takes it; no new accept this cycle.
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      d_sr_q  <= '0;
      bor_q   <= 1'b0;
      bo_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      d_sr_q  <= d_sr_d;
      bor_q   <= bor_d;
      bo_q    <= bo_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign D         = d_sr_q;
  assign BO        = bo_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed + exhaustive bench for serial_subtractor (WIDTH=4) with a
// scoreboard queue filled on accept and drained on result handshake.
module tb_serial_subtractor;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] D;
  logic         BO;

  int vecs = 0;
  int errs = 0;
  int accepts = 0;
  int handshakes = 0;
  logic [W:0] exp_q[$];

  serial_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .D         (D),
    .BO        (BO)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample handshakes at the falling edge, then cross the rising edge.
  task automatic step();
    logic [W:0] e;
    @(negedge clk);
    if (in_valid && in_ready) begin
      exp_q.push_back({W'(A - B), (A < B)});
      accepts++;
    end
    if (out_valid && out_ready) begin
      handshakes++;
      check("sb_has_entry", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("D", 32'(D), 32'(e[W:1]));
        check("BO", 32'(BO), 32'(e[0]));
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Accept one operand pair, check latency, stall the result, then take it.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int stall);
    int n;
    A = a;
    B = b;
    in_valid = 1'b1;
    out_ready = (stall == 0);
    check("accept_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      check("run_in_ready", 32'(in_ready), 32'd0);
      step();
      n++;
    end
    check("latency", n, W);
    for (int i = 0; i < stall; i++) begin
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_D", 32'(D), 32'(W'(a - b)));
      check("stall_BO", 32'(BO), 32'(a < b));
      step();
    end
    out_ready = 1'b1;
    step();
    check("post_valid", 32'(out_valid), 32'd0);
    check("post_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b0;
  endtask

  initial begin
    int n;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_D", 32'(D), 32'd0);
    check("rst_BO", 32'(BO), 32'd0);
    rst_n = 1'b1;
    step();

    // Directed vectors
    run_op(4'd9, 4'd3, 0);
    run_op(4'd3, 4'd9, 0);
    run_op(4'd0, 4'd1, 0);
    run_op(4'd5, 4'd5, 0);

    // Backpressure for three cycles
    run_op(4'd9, 4'd3, 3);

    // in_valid during RUN/DONE must be ignored
    A = 4'd9;
    B = 4'd3;
    in_valid = 1'b1;
    out_ready = 1'b0;
    step();
    A = 4'd1;
    B = 4'd2;
    n = 0;
    while (!out_valid && n < 20) begin
      check("ign_in_ready", 32'(in_ready), 32'd0);
      step();
      n++;
    end
    check("ign_latency", n, W);
    check("ign_done_ready", 32'(in_ready), 32'd0);
    step();
    check("ign_done_ready2", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    check("ign_post_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b0;

    // Asynchronous reset in the second RUN cycle
    A = 4'd9;
    B = 4'd3;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_in_ready", 32'(in_ready), 32'd1);
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_D", 32'(D), 32'd0);
    check("arst_BO", 32'(BO), 32'd0);
    exp_q.delete();
    accepts = 0;
    handshakes = 0;
    step();
    rst_n = 1'b1;
    step();
    run_op(4'd7, 4'd2, 1);

    // Exhaustive sweep with random stalls
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        run_op(W'(a), W'(b), int'($urandom_range(0, 2)));
      end
    end

    check("one_handshake_per_accept", handshakes, accepts);
    check("sb_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
